bus_arbiter: RTL

//  Time-shares the 32-bit datapath bus between its 24 sources: R0-R15, HI, LO, Zhigh, Zlow,
//  PC, MDR, InPort and C_sign_extended. Each source raises a request bit; one winner is picked
//  per cycle by round-robin. The block drives the 5-bit select of the bus multiplexer plus a
//  one-hot grant. It sits between the control unit / requesters and the bus mux.

---
 rtl/bus_arbiter_pkg.sv | 56 +++++
 rtl/bus_arbiter_rr_picker.sv | 40 ++++
 rtl/bus_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the datapath bus arbiter: source codes, sizes, FSM states
// and small vector helpers used by the arbiter and its round-robin picker.
package bus_arbiter_pkg;

    localparam int N_SRC    = 24;
    localparam int SEL_W    = 5;
    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = 4;

    localparam logic [SEL_W-1:0]  SEL_IDLE   = 5'd31;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = 4'd8;

    localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SRC_CSIGN  = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arbState_t;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic moreThanOne(input logic [N_SRC-1:0] vec);
        return (vec & (vec - {{(N_SRC-1){1'b0}}, 1'b1})) != {N_SRC{1'b0}};
    endfunction

    function automatic logic [N_SRC-1:0] oneHot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] vec;
        vec      = {N_SRC{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first unmasked request at or above rrPtr,
// wrapping from the top source back to source 0.
module bus_arbiter_rr_picker
    import bus_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] mask,
    input  logic [SEL_W-1:0] rrPtr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0]   WRAP_EXT = 6'd24;
    localparam logic [SEL_W-1:0] WRAP     = 5'd24;

    logic [N_SRC-1:0] masked_s;
    logic [N_SRC-1:0] rotated_s;
    logic [SEL_W-1:0] offset_s;
    logic [SEL_W:0]   sum_s;

    // Rotate so rrPtr lands on bit 0, priority-encode, then rotate the index back.
    always_comb begin
        masked_s  = req & ~mask;
        rotated_s = (masked_s >> rrPtr) | (masked_s << (WRAP - rrPtr));
        offset_s  = {SEL_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            offset_s = rotated_s[i] ? SEL_W'(i) : offset_s;
        end
        found = |rotated_s;
        sum_s = {1'b0, rrPtr} + {1'b0, offset_s};
        if (!found) begin
            idx = SEL_IDLE;
        end else if (sum_s >= WRAP_EXT) begin
            idx = rrPtr + offset_s - WRAP;
        end else begin
            idx = sum_s[SEL_W-1:0];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 24-source datapath bus with lock-based multi-cycle
// hold, bounded hold length and registered grant/select outputs.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    input  logic             lock,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] select_signal,
    output logic             bus_valid,
    output logic             multi_req,
    output logic             hold_timeout
);

    arbState_t         state_r;
    logic [SEL_W-1:0]  rrPtr_r;
    logic [HOLD_W-1:0] holdCnt_r;

    logic             keepBus_s;
    logic             forceRelease_s;
    logic             arbitrate_s;
    logic [N_SRC-1:0] mask_s;
    logic             found_s;
    logic [SEL_W-1:0] winner_s;

    bus_arbiter_rr_picker uPicker (
        .req   (req),
        .mask  (mask_s),
        .rrPtr (rrPtr_r),
        .found (found_s),
        .idx   (winner_s)
    );

    // Decide whether this edge re-arbitrates or extends the current owner's tenure.
    always_comb begin
        keepBus_s      = lock && ((req & grant) != {N_SRC{1'b0}});
        forceRelease_s = (state_r == HOLD) && keepBus_s && (holdCnt_r >= HOLD_LIMIT);
        mask_s         = forceRelease_s ? grant : {N_SRC{1'b0}};
        case (state_r)
            IDLE:    arbitrate_s = 1'b1;
            GRANT:   arbitrate_s = !keepBus_s;
            HOLD:    arbitrate_s = !keepBus_s || forceRelease_s;
            default: arbitrate_s = 1'b1;
        endcase
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r       <= IDLE;
            rrPtr_r       <= {SEL_W{1'b0}};
            holdCnt_r     <= {HOLD_W{1'b0}};
            grant         <= {N_SRC{1'b0}};
            select_signal <= SEL_IDLE;
            bus_valid     <= 1'b0;
            multi_req     <= 1'b0;
            hold_timeout  <= 1'b0;
        end else if (arbitrate_s) begin
            holdCnt_r    <= {HOLD_W{1'b0}};
            hold_timeout <= hold_timeout | forceRelease_s;
            if (found_s) begin
                state_r       <= GRANT;
                grant         <= oneHot(winner_s);
                select_signal <= winner_s;
                bus_valid     <= 1'b1;
                multi_req     <= moreThanOne(req);
                rrPtr_r       <= (winner_s == SRC_CSIGN) ? {SEL_W{1'b0}} : winner_s + 5'd1;
            end else begin
                state_r       <= IDLE;
                grant         <= {N_SRC{1'b0}};
                select_signal <= SEL_IDLE;
                bus_valid     <= 1'b0;
                multi_req     <= 1'b0;
            end
        end else if (state_r == GRANT) begin
            state_r   <= HOLD;
            holdCnt_r <= 4'd1;
        end else begin
            holdCnt_r <= holdCnt_r + 4'd1;
        end
    end

endmodule
